seq_tx_1101_framer: RTL and testbench

- Serial frame transmitter paired with the Mealy non-overlapping 1101 sequence detector.
- Accepts a parallel payload word over a valid/ready handshake and emits it on a single serial line `dout`.
- Each frame is the sync pattern 1101 followed by the payload, MSB first.
- Zero-bit stuffing guarantees the detector sees 1101 only at frame start.

---
 rtl/seq_tx_1101_framer.sv | 158 +++++++++++++++
 tb/tb_seq_tx_1101_framer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_tx_1101_framer.sv
// seq_tx_1101_framer
// Serial frame transmitter: sends the sync pattern 1101 followed by a
// DATA_W-bit payload (MSB first) on a single registered line. A zero is
// stuffed whenever the last three line bits were 110, so a 1101 detector
// on the far end can only ever lock onto the sync pattern.
//
// Timing model: the state register describes what dout carries *now*.
//   IDLE  : dout = 0, block accepts a payload word
//   SYNC  : dout = sync bit number cnt (0..3 -> 1,1,0,1)
//   DATA  : dout = payload bit, cnt = payload bits sent including this one
//   STUFF : dout = stuffed 0, cnt unchanged
// Every edge computes the next dout value from the current state and the
// three-bit line history h (h[0] is the bit on dout this cycle).

module seq_tx_1101_framer #(
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              dout,
   output logic              busy,
   output logic              frame_done
);

   // Counter holds either the sync bit index (0..3) or the number of
   // payload bits already on the line (1..DATA_W).
   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_SYNC_END = CNT_W'(3);

   // Line history that forces a stuff bit: the next bit would otherwise
   // be free to complete a 1101.
   localparam logic [2:0] STUFF_HIST = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_STUFF
   } state_t;

   state_t            state_q, state_d;
   logic              dout_q, dout_d;
   logic              done_q, done_d;
   logic [2:0]        h_q, h_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              data_step;

   // Control registers: state, line bit, frame_done, history and counter.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         dout_q  <= 1'b0;
         done_q  <= 1'b0;
         h_q     <= 3'b000;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         h_q     <= h_d;
         cnt_q   <= cnt_d;
      end
   end

   // Payload shift register; the MSB is always the next payload bit to send.
   // NOTE: no reset here on purpose -- the word is reloaded on every accept
   // and is never observed in IDLE, so resetting it would only add logic.
   always_ff @(posedge clock) begin
      sh_q <= sh_d;
   end

   // Next-state and next-line-bit decision.
   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      dout_d    = 1'b0;
      done_d    = 1'b0;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      data_step = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (din_valid) begin
               state_d = ST_SYNC;
               sh_d    = din;
               dout_d  = 1'b1;        // first sync bit
               cnt_d   = '0;
            end
         end

         ST_SYNC: begin
            if (cnt_q == CNT_SYNC_END) begin
               data_step = 1'b1;
            end else begin
               cnt_d  = cnt_q + CNT_W'(1);
               // Sync bits 1,1,0,1: only index 2 is a zero.
               dout_d = (cnt_q != CNT_W'(1));
            end
         end

         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               // Last payload bit is on the line; the IDLE zero that follows
               // also breaks any trailing 110.
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               data_step = 1'b1;
            end
         end

         ST_STUFF: begin
            data_step = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Shared payload/stuff decision; history carries over from the sync
      // tail, so the first payload bit is checked like any other.
      if (data_step) begin
         if (h_q == STUFF_HIST) begin
            state_d = ST_STUFF;
            dout_d  = 1'b0;
            if (state_q == ST_SYNC) begin
               cnt_d = '0;
            end
         end else begin
            state_d = ST_DATA;
            dout_d  = sh_q[DATA_W-1];
            sh_d    = {sh_q[DATA_W-2:0], 1'b0};
            cnt_d   = (state_q == ST_SYNC) ? CNT_W'(1) : cnt_q + CNT_W'(1);
            done_d  = (cnt_d == CNT_LAST);
         end
      end

      h_d = {h_q[1:0], dout_d};
   end

   // Handshake and status outputs derive directly from registered state.
   assign din_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign dout       = dout_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_seq_tx_1101_framer.sv
// tb_seq_tx_1101_framer
// Self-checking bench: a frame-level model (sync pattern + stuffed payload
// built from the line rules) predicts every output each cycle; directed
// scenarios pin the model and the DUT against hand-derived bit streams.

module tb_seq_tx_1101_framer;

   localparam int DW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] din = '0;
   logic          din_valid = 1'b0;
   logic          din_ready;
   logic          dout;
   logic          busy;
   logic          frame_done;

   int n_pass  = 0;
   int n_total = 0;

   seq_tx_1101_framer #(.DATA_W(DW)) dut (
      .clock      (clock),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] actual,
                        input logic [63:0] expected);
      n_total++;
      if (actual === expected) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Frame builder: line bits in send order, first bit in the MSB of the
   // low 'len' bits. Stuff a 0 whenever the last three sent bits are 110.
   function automatic int build_frame(input logic [DW-1:0] p, output logic [63:0] seq);
      logic [2:0] h;
      int len;
      logic [3:0] sync;
      seq  = '0;
      len  = 0;
      h    = 3'b000;
      sync = 4'b1101;
      for (int i = 3; i >= 0; i--) begin
         seq = {seq[62:0], sync[i]};
         h   = {h[1:0], sync[i]};
         len++;
      end
      for (int i = DW - 1; i >= 0; i--) begin
         while (h == 3'b110) begin
            seq = {seq[62:0], 1'b0};
            h   = {h[1:0], 1'b0};
            len++;
         end
         seq = {seq[62:0], p[i]};
         h   = {h[1:0], p[i]};
         len++;
      end
      return len;
   endfunction

   // ---------------- behavioural model ----------------
   bit          m_valid = 0;
   bit          m_busy  = 0;
   logic        m_dout  = 1'b0;
   logic        m_done  = 1'b0;
   logic [63:0] m_seq   = '0;
   int          m_len   = 0;
   int          m_pos   = 0;
   int          exp_syncs = 0;

   initial forever begin
      @(posedge clock);
      if (reset) begin
         m_valid = 1;
         m_busy  = 0;
         m_dout  = 1'b0;
         m_done  = 1'b0;
      end else if (m_valid) begin
         if (m_busy) begin
            if (m_pos == m_len) begin
               m_busy = 0;
               m_dout = 1'b0;
               m_done = 1'b0;
            end else begin
               m_dout = m_seq[m_len-1-m_pos];
               m_pos++;
               m_done = (m_pos == m_len);
               if (m_pos == 4) exp_syncs++;
            end
         end else begin
            m_dout = 1'b0;
            m_done = 1'b0;
            if (din_valid) begin
               m_len  = build_frame(din, m_seq);
               m_busy = 1;
               m_dout = m_seq[m_len-1];
               m_pos  = 1;
            end
         end
      end
   end

   // ---------------- per-cycle compare + line detector ----------------
   logic [3:0] det_w   = '0;
   int         det_len = 0;
   int         det_hits = 0;

   initial forever begin
      @(negedge clock);
      if (m_valid) begin
         check("dout",       64'(dout),       64'(m_dout));
         check("frame_done", 64'(frame_done), 64'(m_done));
         check("busy",       64'(busy),       64'(m_busy));
         check("din_ready",  64'(din_ready),  64'(!m_busy));
         // Non-overlapping 1101 scan of the actual line.
         det_w = {det_w[2:0], dout};
         det_len++;
         if (det_len >= 4 && det_w == 4'b1101) begin
            det_hits++;
            det_len = 0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   // Send one word from IDLE and record the line until the block idles.
   task automatic capture(input logic [DW-1:0] p, output logic [63:0] seq,
                          output int len, output int done_pos);
      din       = p;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      seq = '0;
      len = 0;
      done_pos = -1;
      while (busy && len < 64) begin
         seq = {seq[62:0], dout};
         len++;
         if (frame_done) done_pos = len;
         tick();
      end
      check("frame_bounded", 64'(len < 64), 64'(1));
      check("post_dout",  64'(dout), 64'(0));
      check("post_ready", 64'(din_ready), 64'(1));
   endtask

   logic [63:0] seq;
   int          len;
   int          dpos;
   int          idle_cnt;
   int          hits;
   logic [3:0]  w;

   initial begin
      // Model pins: hand-derived frames.
      len = build_frame(8'hFF, seq);
      check("model_ff_len", 64'(len), 64'(12));
      check("model_ff",     seq, 64'b1101_1111_1111);
      len = build_frame(8'hD0, seq);
      check("model_d0_len", 64'(len), 64'(13));
      check("model_d0",     seq, 64'b1101_1100_10000);
      len = build_frame(8'hDD, seq);
      check("model_dd_len", 64'(len), 64'(14));
      check("model_dd",     seq, 64'b1101_1100_1110_01);
      len = build_frame(8'h68, seq);
      check("model_68",     seq, 64'b1101_0110_0_1000);

      // Reset with din_valid high: outputs idle throughout, accept right after.
      reset = 1'b1;
      din = 8'hFF;
      din_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_dout",  64'(dout), 64'(0));
         check("rst_ready", 64'(din_ready), 64'(1));
         check("rst_busy",  64'(busy), 64'(0));
      end
      reset = 1'b0;
      tick();
      din_valid = 1'b0;
      check("post_rst_accept_busy", 64'(busy), 64'(1));
      check("post_rst_accept_dout", 64'(dout), 64'(1));
      while (busy) tick();

      // Directed frames.
      capture(8'hFF, seq, len, dpos);
      check("ff_seq", seq, 64'b1101_1111_1111);
      check("ff_len", 64'(len), 64'(12));
      check("ff_done_pos", 64'(dpos), 64'(12));

      capture(8'hD0, seq, len, dpos);
      check("d0_seq", seq, 64'b1101_1100_10000);
      check("d0_done_pos", 64'(dpos), 64'(13));

      capture(8'hDD, seq, len, dpos);
      check("dd_seq", seq, 64'b1101_1100_1110_01);
      check("dd_done_pos", 64'(dpos), 64'(14));
      // Detector view of 0 + frame + 0: exactly one hit.
      seq = {seq[62:0], 1'b0};
      hits = 0;
      w = '0;
      for (int i = len; i >= 0; i--) begin
         w = {w[2:0], seq[i]};
         if (w == 4'b1101) begin hits++; w = '0; end
      end
      check("dd_detector_hits", 64'(hits), 64'(1));

      // Back-to-back with din_valid held high.
      din = 8'h68;
      din_valid = 1'b1;
      tick();
      din = 8'hDD;
      seq = '0;
      idle_cnt = 0;
      for (int i = 0; i < 28; i++) begin
         seq = {seq[62:0], dout};
         if (!busy) idle_cnt++;
         tick();
      end
      din_valid = 1'b0;
      check("b2b_seq", seq, {36'd0, 13'b1101_0110_0_1000, 1'b0, 14'b1101_1100_1110_01});
      check("b2b_idle_cycles", 64'(idle_cnt), 64'(1));
      len = 0;
      while (busy && len < 64) begin tick(); len++; end
      check("b2b_drain_bounded", 64'(len < 64), 64'(1));

      // Reset while payload bit 3 of 8'hDD is on the line (frame cycle 10).
      din = 8'hDD;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check("abort_bit3_value", 64'(dout), 64'(1));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_dout",  64'(dout), 64'(0));
      check("abort_busy",  64'(busy), 64'(0));
      check("abort_ready", 64'(din_ready), 64'(1));
      capture(8'hFF, seq, len, dpos);
      check("after_abort_ff_seq", seq, 64'b1101_1111_1111);
      check("after_abort_ff_done_pos", 64'(dpos), 64'(12));

      // Randomized traffic with occasional resets; the model checks each cycle.
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 149) == 0);
         din_valid = ($urandom_range(0, 3) != 0);
         din       = DW'($urandom);
         tick();
      end
      reset = 1'b0;
      din_valid = 1'b0;
      len = 0;
      while (busy && len < 64) begin tick(); len++; end
      check("rand_drain_bounded", 64'(len < 64), 64'(1));
      tick();
      tick();
      check("detector_hits_vs_syncs", 64'(det_hits), 64'(exp_syncs));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
